// File: rtl/sp_types_pkg.sv
// Shared widths, opcodes and FIFO word layouts for the scratchpad bank controller.
package sp_types_pkg;

    localparam int BITS_PER_ROW = 64;
    localparam int MAT_S_W      = 2;
    localparam int ROW_S_W      = 2;
    localparam int WORD_W       = 32;
    localparam int NUM_MATS     = 1 << MAT_S_W;
    localparam int NUM_ROWS     = 1 << ROW_S_W;
    localparam int ADDR_W       = MAT_S_W + ROW_S_W;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_STORE = 2'b01,
        OP_GEMM  = 2'b10,
        OP_RSVD  = 2'b11
    } sp_op_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } sp_state_t;

    typedef struct packed {
        logic                    rsvd;
        logic [MAT_S_W-1:0]      mat;
        logic [ROW_S_W-1:0]      row;
        logic [BITS_PER_ROW-1:0] data;
    } sp_wreq_t;

    typedef struct packed {
        sp_op_t              op;
        logic [MAT_S_W-1:0]  mat;
        logic [ROW_S_W-1:0]  row;
        logic [WORD_W-1:0]   addr;
    } sp_rreq_t;

endpackage

// File: rtl/sp_bank_array.sv
// Row storage for one bank: one write port and one registered read port, no reset on contents.
module sp_bank_array #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sp_bank_ctrl.sv
// Scratchpad bank controller: arbitrates row writes against row reads and forwards
// read rows to the GEMM input FIFO or the store FIFO.
module sp_bank_ctrl
    import sp_types_pkg::*;
#(
    parameter int BANK_ID    = 0,
    parameter int MAX_WR_RUN = 4
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               wFIFO_empty,
    input  logic [$bits(sp_wreq_t)-1:0]        wFIFO_rdata,
    output logic                               wFIFO_REN,
    input  logic                               rFIFO_empty,
    input  logic [$bits(sp_rreq_t)-1:0]        rFIFO_rdata,
    output logic                               rFIFO_REN,
    input  logic                               gemm_full,
    output logic                               gemm_WEN,
    output logic [BITS_PER_ROW+ROW_S_W-1:0]    gemm_wdata,
    input  logic                               store_full,
    output logic                               store_WEN,
    output logic [2+WORD_W+BITS_PER_ROW-1:0]   store_wdata,
    output logic                               busy,
    output logic                               err_op
);

    localparam int                  RUN_W    = $clog2(MAX_WR_RUN + 1);
    localparam logic [RUN_W-1:0]    RUN_MAX  = RUN_W'(MAX_WR_RUN);
    localparam logic [1:0]          BANK_TAG = BANK_ID[1:0];

    sp_wreq_t               wreq;
    sp_rreq_t               rreq;
    sp_state_t              state_q;
    logic [RUN_W-1:0]       run_q;
    logic                   gemm_wen_q;
    logic                   store_wen_q;
    logic                   err_q;
    logic [ROW_S_W-1:0]     row_q;
    logic [WORD_W-1:0]      addr_q;
    logic [BITS_PER_ROW-1:0] rd_data;
    logic                   target_full;
    logic                   rd_ready;
    logic                   hazard;
    logic                   wr_grant;
    logic                   rd_grant;
    logic                   rd_legal;
    logic                   unused_rsvd;

    assign wreq        = sp_wreq_t'(wFIFO_rdata);
    assign rreq        = sp_rreq_t'(rFIFO_rdata);
    assign unused_rsvd = wreq.rsvd;

    // Illegal ops never touch a target FIFO, so they are never blocked by one.
    always_comb begin
        target_full = 1'b0;
        if (rreq.op == OP_GEMM) begin
            target_full = gemm_full;
        end else if (rreq.op == OP_STORE) begin
            target_full = store_full;
        end
    end

    assign rd_ready = !rFIFO_empty && !target_full;
    assign hazard   = !wFIFO_empty && !rFIFO_empty &&
                      ({rreq.mat, rreq.row} == {wreq.mat, wreq.row});

    always_comb begin
        wr_grant = 1'b0;
        rd_grant = 1'b0;
        if (!RST) begin
            if (state_q == ST_IDLE) begin
                if (hazard) begin
                    wr_grant = 1'b1;
                end else if (rd_ready && (run_q == RUN_MAX)) begin
                    rd_grant = 1'b1;
                end else if (!wFIFO_empty) begin
                    wr_grant = 1'b1;
                end else if (rd_ready) begin
                    rd_grant = 1'b1;
                end
            end else begin
                wr_grant = !wFIFO_empty;
            end
        end
    end

    assign rd_legal  = rd_grant && ((rreq.op == OP_GEMM) || (rreq.op == OP_STORE));
    assign wFIFO_REN = wr_grant;
    assign rFIFO_REN = rd_grant;

    sp_bank_array #(
        .DEPTH  (NUM_MATS * NUM_ROWS),
        .DATA_W (BITS_PER_ROW),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (CLK),
        .we_i    (wr_grant),
        .waddr_i ({wreq.mat, wreq.row}),
        .wdata_i (wreq.data),
        .re_i    (rd_legal),
        .raddr_i ({rreq.mat, rreq.row}),
        .rdata_o (rd_data)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            run_q       <= '0;
            gemm_wen_q  <= 1'b0;
            store_wen_q <= 1'b0;
            err_q       <= 1'b0;
            row_q       <= '0;
            addr_q      <= '0;
        end else begin
            gemm_wen_q  <= rd_legal && (rreq.op == OP_GEMM);
            store_wen_q <= rd_legal && (rreq.op == OP_STORE);
            if (rd_legal) begin
                row_q  <= rreq.row;
                addr_q <= rreq.addr;
            end
            if (rd_grant && !rd_legal) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE:    state_q <= rd_legal ? ST_RD_WAIT : ST_IDLE;
                ST_RD_WAIT: state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
            if (rd_grant || rFIFO_empty) begin
                run_q <= '0;
            end else if (wr_grant && (run_q != RUN_MAX)) begin
                run_q <= run_q + 1'b1;
            end
        end
    end

    // Data paths are masked so idle and reset cycles present all-zero words.
    assign gemm_WEN    = gemm_wen_q;
    assign store_WEN   = store_wen_q;
    assign gemm_wdata  = gemm_wen_q  ? {row_q, rd_data} : '0;
    assign store_wdata = store_wen_q ? {BANK_TAG, addr_q, rd_data} : '0;
    assign busy        = !RST && ((state_q == ST_RD_WAIT) || !wFIFO_empty || !rFIFO_empty);
    assign err_op      = err_q;

endmodule

// File: tb/tb_sp_bank_ctrl.sv
// Directed bench for sp_bank_ctrl: queue-backed input FIFOs, hand-computed expectations.
module tb_sp_bank_ctrl;
    import sp_types_pkg::*;

    localparam int WQ_W = $bits(sp_wreq_t);
    localparam int RQ_W = $bits(sp_rreq_t);
    localparam logic [63:0] D1 = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] D2 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] DA = 64'hAAAA_0000_AAAA_0003;
    localparam logic [63:0] DB = 64'hBBBB_0000_BBBB_0003;

    logic                             CLK;
    logic                             RST;
    logic                             wFIFO_empty;
    logic [WQ_W-1:0]                  wFIFO_rdata;
    logic                             wFIFO_REN;
    logic                             rFIFO_empty;
    logic [RQ_W-1:0]                  rFIFO_rdata;
    logic                             rFIFO_REN;
    logic                             gemm_full;
    logic                             gemm_WEN;
    logic [BITS_PER_ROW+ROW_S_W-1:0]  gemm_wdata;
    logic                             store_full;
    logic                             store_WEN;
    logic [2+WORD_W+BITS_PER_ROW-1:0] store_wdata;
    logic                             busy;
    logic                             err_op;

    logic [WQ_W-1:0] wq[$];
    logic [RQ_W-1:0] rq[$];
    int errors;
    int checks;

    sp_bank_ctrl #(.BANK_ID(2), .MAX_WR_RUN(4)) dut (
        .CLK(CLK), .RST(RST),
        .wFIFO_empty(wFIFO_empty), .wFIFO_rdata(wFIFO_rdata), .wFIFO_REN(wFIFO_REN),
        .rFIFO_empty(rFIFO_empty), .rFIFO_rdata(rFIFO_rdata), .rFIFO_REN(rFIFO_REN),
        .gemm_full(gemm_full), .gemm_WEN(gemm_WEN), .gemm_wdata(gemm_wdata),
        .store_full(store_full), .store_WEN(store_WEN), .store_wdata(store_wdata),
        .busy(busy), .err_op(err_op)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [WQ_W-1:0] mk_w(input logic [1:0] mat, input logic [1:0] row,
                                             input logic [63:0] data);
        return {1'b0, mat, row, data};
    endfunction

    function automatic logic [RQ_W-1:0] mk_r(input logic [1:0] op, input logic [1:0] mat,
                                             input logic [1:0] row, input logic [31:0] addr);
        return {op, mat, row, addr};
    endfunction

    task automatic drive_fifos();
        wFIFO_empty = (wq.size() == 0);
        wFIFO_rdata = (wq.size() == 0) ? '0 : wq[0];
        rFIFO_empty = (rq.size() == 0);
        rFIFO_rdata = (rq.size() == 0) ? '0 : rq[0];
        #1;
    endtask

    // Advance one clock: pops whatever the DUT requested, then settles inputs.
    task automatic step();
        logic wp;
        logic rp;
        wp = wFIFO_REN;
        rp = rFIFO_REN;
        @(posedge CLK);
        #1;
        if (wp && wq.size() > 0) void'(wq.pop_front());
        if (rp && rq.size() > 0) void'(rq.pop_front());
        drive_fifos();
    endtask

    task automatic test_reset();
        RST = 1'b1; gemm_full = 1'b0; store_full = 1'b0;
        wq.push_back(mk_w(2'd0, 2'd0, 64'h5));
        drive_fifos();
        #2;
        checks++; if ({wFIFO_REN, rFIFO_REN, gemm_WEN, store_WEN} !== 4'b0000) begin errors++;
            $display("FAIL reset_ren_wen: got %b expected 0000", {wFIFO_REN, rFIFO_REN, gemm_WEN, store_WEN}); end
        checks++; if ({busy, err_op} !== 2'b00) begin errors++;
            $display("FAIL reset_busy_err: got %b expected 00", {busy, err_op}); end
        checks++; if (gemm_wdata !== '0 || store_wdata !== '0) begin errors++;
            $display("FAIL reset_wdata: got %h/%h expected 0", gemm_wdata, store_wdata); end
        wq.delete();
        drive_fifos();
        @(posedge CLK); #2;
        RST = 1'b0;
        #1;
        $display("test_reset done");
    endtask

    task automatic test_gemm_read();
        wq.push_back(mk_w(2'd2, 2'd1, D1));
        drive_fifos();
        checks++; if (wFIFO_REN !== 1'b1) begin errors++;
            $display("FAIL gemm_wren: got %b expected 1", wFIFO_REN); end
        step();
        rq.push_back(mk_r(2'b10, 2'd2, 2'd1, 32'h0));
        drive_fifos();
        checks++; if (rFIFO_REN !== 1'b1 || gemm_WEN !== 1'b0) begin errors++;
            $display("FAIL gemm_issue: got ren=%b wen=%b expected ren=1 wen=0", rFIFO_REN, gemm_WEN); end
        step();
        checks++; if (gemm_WEN !== 1'b1 || store_WEN !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL gemm_wen: got gemm=%b store=%b busy=%b expected 1 0 1", gemm_WEN, store_WEN, busy); end
        checks++; if (gemm_wdata !== {2'd1, D1}) begin errors++;
            $display("FAIL gemm_wdata: got %h expected %h", gemm_wdata, {2'd1, D1}); end
        step();
        checks++; if (gemm_WEN !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL gemm_done: got wen=%b busy=%b expected 0 0", gemm_WEN, busy); end
        $display("test_gemm_read done");
    endtask

    task automatic test_store_read();
        wq.push_back(mk_w(2'd1, 2'd2, D2));
        drive_fifos();
        step();
        rq.push_back(mk_r(2'b01, 2'd1, 2'd2, 32'h0000_1000));
        drive_fifos();
        checks++; if (rFIFO_REN !== 1'b1) begin errors++;
            $display("FAIL store_issue: got %b expected 1", rFIFO_REN); end
        step();
        checks++; if (store_WEN !== 1'b1 || gemm_WEN !== 1'b0) begin errors++;
            $display("FAIL store_wen: got store=%b gemm=%b expected 1 0", store_WEN, gemm_WEN); end
        checks++; if (store_wdata !== {2'd2, 32'h0000_1000, D2}) begin errors++;
            $display("FAIL store_wdata: got %h expected %h", store_wdata, {2'd2, 32'h0000_1000, D2}); end
        step();
        $display("test_store_read done");
    endtask

    task automatic test_hazard();
        wq.push_back(mk_w(2'd0, 2'd3, DA));
        drive_fifos();
        step();
        rq.push_back(mk_r(2'b10, 2'd0, 2'd3, 32'h0));
        for (int i = 0; i < 4; i++) wq.push_back(mk_w(2'd3, 2'(i), 64'(i)));
        wq.push_back(mk_w(2'd0, 2'd3, DB));
        drive_fifos();
        for (int i = 0; i < 5; i++) begin
            checks++; if (wFIFO_REN !== 1'b1 || rFIFO_REN !== 1'b0) begin errors++;
                $display("FAIL hazard_write%0d: got wren=%b rren=%b expected 1 0", i, wFIFO_REN, rFIFO_REN); end
            step();
        end
        checks++; if (rFIFO_REN !== 1'b1) begin errors++;
            $display("FAIL hazard_read: got %b expected 1", rFIFO_REN); end
        step();
        checks++; if (gemm_WEN !== 1'b1 || gemm_wdata !== {2'd3, DB}) begin errors++;
            $display("FAIL hazard_data: got wen=%b data=%h expected 1 %h", gemm_WEN, gemm_wdata, {2'd3, DB}); end
        step();
        $display("test_hazard done");
    endtask

    task automatic test_run_limit();
        int  nwr;
        bit  seen;
        nwr = 0; seen = 1'b0;
        rq.push_back(mk_r(2'b10, 2'd2, 2'd1, 32'h0));
        for (int i = 0; i < 4; i++) wq.push_back(mk_w(2'd3, 2'(i), 64'(i + 16)));
        for (int i = 0; i < 3; i++) wq.push_back(mk_w(2'd0, 2'(i), 64'(i + 32)));
        wq.push_back(mk_w(2'd1, 2'd0, 64'h77));
        drive_fifos();
        for (int c = 0; c < 20; c++) begin
            if (rFIFO_REN) begin seen = 1'b1; break; end
            if (wFIFO_REN) nwr++;
            step();
        end
        checks++; if (!seen || nwr != 4) begin errors++;
            $display("FAIL run_limit: got seen=%0d writes=%0d expected seen=1 writes=4", seen, nwr); end
        step();
        checks++; if (gemm_WEN !== 1'b1 || gemm_wdata !== {2'd1, D1} || wFIFO_REN !== 1'b1) begin errors++;
            $display("FAIL run_rdwait: got wen=%b data=%h wren=%b expected 1 %h 1", gemm_WEN, gemm_wdata, wFIFO_REN, {2'd1, D1}); end
        for (int c = 0; c < 20; c++) begin
            if (wq.size() == 0 && !busy) break;
            step();
        end
        checks++; if (wq.size() != 0 || busy !== 1'b0) begin errors++;
            $display("FAIL run_drain: got left=%0d busy=%b expected 0 0", wq.size(), busy); end
        $display("test_run_limit done");
    endtask

    task automatic test_store_full();
        store_full = 1'b1;
        rq.push_back(mk_r(2'b01, 2'd1, 2'd2, 32'h0000_2000));
        wq.push_back(mk_w(2'd0, 2'd0, 64'h100));
        wq.push_back(mk_w(2'd0, 2'd1, 64'h101));
        drive_fifos();
        for (int i = 0; i < 2; i++) begin
            checks++; if (rFIFO_REN !== 1'b0 || wFIFO_REN !== 1'b1) begin errors++;
                $display("FAIL full_drain%0d: got rren=%b wren=%b expected 0 1", i, rFIFO_REN, wFIFO_REN); end
            step();
        end
        checks++; if (rFIFO_REN !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL full_stall: got rren=%b busy=%b expected 0 1", rFIFO_REN, busy); end
        step();
        store_full = 1'b0;
        #1;
        checks++; if (rFIFO_REN !== 1'b1) begin errors++;
            $display("FAIL full_release: got %b expected 1", rFIFO_REN); end
        step();
        checks++; if (store_WEN !== 1'b1 || store_wdata !== {2'd2, 32'h0000_2000, D2}) begin errors++;
            $display("FAIL full_data: got wen=%b data=%h expected 1 %h", store_WEN, store_wdata, {2'd2, 32'h0000_2000, D2}); end
        step();
        $display("test_store_full done");
    endtask

    task automatic test_back_to_back();
        rq.push_back(mk_r(2'b10, 2'd2, 2'd1, 32'h0));
        rq.push_back(mk_r(2'b10, 2'd0, 2'd3, 32'h0));
        drive_fifos();
        checks++; if (rFIFO_REN !== 1'b1) begin errors++;
            $display("FAIL b2b_first: got %b expected 1", rFIFO_REN); end
        step();
        checks++; if (rFIFO_REN !== 1'b0 || gemm_WEN !== 1'b1) begin errors++;
            $display("FAIL b2b_gap: got rren=%b wen=%b expected 0 1", rFIFO_REN, gemm_WEN); end
        step();
        checks++; if (rFIFO_REN !== 1'b1) begin errors++;
            $display("FAIL b2b_second: got %b expected 1", rFIFO_REN); end
        step();
        checks++; if (gemm_WEN !== 1'b1 || gemm_wdata !== {2'd3, DB}) begin errors++;
            $display("FAIL b2b_data: got wen=%b data=%h expected 1 %h", gemm_WEN, gemm_wdata, {2'd3, DB}); end
        step();
        $display("test_back_to_back done");
    endtask

    task automatic test_illegal_and_reset();
        rq.push_back(mk_r(2'b11, 2'd0, 2'd0, 32'h0));
        drive_fifos();
        checks++; if (rFIFO_REN !== 1'b1) begin errors++;
            $display("FAIL illegal_pop: got %b expected 1", rFIFO_REN); end
        step();
        checks++; if (err_op !== 1'b1 || gemm_WEN !== 1'b0 || store_WEN !== 1'b0) begin errors++;
            $display("FAIL illegal_err: got err=%b gemm=%b store=%b expected 1 0 0", err_op, gemm_WEN, store_WEN); end
        rq.push_back(mk_r(2'b10, 2'd2, 2'd1, 32'h0));
        drive_fifos();
        step();
        checks++; if (err_op !== 1'b1 || gemm_WEN !== 1'b1) begin errors++;
            $display("FAIL illegal_sticky: got err=%b wen=%b expected 1 1", err_op, gemm_WEN); end
        RST = 1'b1;
        wq.push_back(mk_w(2'd0, 2'd0, 64'h200));
        drive_fifos();
        checks++; if ({gemm_WEN, store_WEN, wFIFO_REN, rFIFO_REN, busy, err_op} !== 6'b0) begin errors++;
            $display("FAIL rst_outputs: got %b expected 000000", {gemm_WEN, store_WEN, wFIFO_REN, rFIFO_REN, busy, err_op}); end
        checks++; if (gemm_wdata !== '0 || store_wdata !== '0) begin errors++;
            $display("FAIL rst_wdata: got %h/%h expected 0", gemm_wdata, store_wdata); end
        #1;
        RST = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (gemm_WEN !== 1'b0 || store_WEN !== 1'b0) begin errors++;
                $display("FAIL rst_no_wen%0d: got gemm=%b store=%b expected 0 0", i, gemm_WEN, store_WEN); end
        end
        $display("test_illegal_and_reset done");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_gemm_read();
        test_store_read();
        test_hazard();
        test_run_limit();
        test_store_full();
        test_back_to_back();
        test_illegal_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

endmodule
